hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised successor to the fixed 2-source, 2-bypass forward/stall pair.
//  Tracks destination tags of in-flight instructions across DEPTH post-ID stages (EX..WB).
//  Each tag carries a per-instruction result latency.
//  Combinationally drives per-source bypass selects and a single load-use/multi-cycle stall for the ID stage.
//  Sits between decode (control_main) and the EX operand muxes.
// PARAMETERS
//  AW       5  register address width (2**AW architectural regs, reg 0 hardwired zero)
//  NSRC     2  number of source operands looked up per cycle
//  DEPTH    3  tracked stages after ID (index 0 = EX, DEPTH-1 = WB)
//  MAX_LAT  2  max stages before result is bypassable (ALU=0, LW=1, MUL=2)
//  LW_      $clog2(MAX_LAT+1) latency field width (derived)
//  SW       $clog2(DEPTH+1) fwd select width (derived)
// PORTS
//  clock         in   1          rising-edge clock
//  reset         in   1          asynchronous, active-low reset
//  id_issue      in   1          ID holds a valid instruction requesting issue
//  id_reg_write  in   1          that instruction writes a register
//  id_rd         in   AW         its destination register
//  id_lat        in   LW_        stages until result bypassable (0..MAX_LAT)
//  id_src_addr   in   NSRC*AW    source register addresses, packed, src0 in LSBs
//  id_src_used   in   NSRC       per-source valid (unused sources never stall/forward)
//  flush         in   1          squash the ID instruction this cycle (branch taken)
//  stall         out  1          hold PC and IF/ID, inject bubble into EX
//  fwd_sel       out  NSRC*SW    per source: 0 = register file, k+1 = bypass from stage k
//  stage_valid   out  DEPTH      debug: tag valid per stage
// BEHAVIOUR
//  State: DEPTH entries {valid, rd[AW], lat_left[LW_]}; no other state.
//  Reset (async, reset==0): all valid=0, rd=0, lat_left=0; hence stall=0, fwd_sel=0.
//  Every clock edge, the pipeline shifts: entry k -> k+1; entry DEPTH-1 retires.
//    - lat_left decrements on each shift, saturating at 0.
//    - No back-pressure from downstream.
//  Stage-0 load:
//    - issued = id_issue & ~stall & ~flush.
//    - Entry0 <= {issued & id_reg_write & (id_rd!=0), id_rd, id_lat}.
//    - Otherwise entry0 <= bubble (valid=0).
//  Lookup (combinational, per source i with id_src_used[i]=1 and addr!=0):
//    - Find the smallest k with valid[k] & rd[k]==addr (youngest producer wins; WAW safe).
//    - If found and lat_left[k]==0: fwd_sel_i = k+1, no stall contribution.
//    - If found and lat_left[k]!=0: stall contribution; fwd_sel_i = 0 (don't care).
//    - If not found: fwd_sel_i = 0 (RF; WB write-through is the RF's responsibility).
//  Source addr 0 or id_src_used[i]=0: fwd_sel_i = 0, never stalls.
//  stall = OR of source contributions, gated by id_issue; flush does not mask stall.
//  Latency: a tag issued in cycle t is visible to lookup in cycle t+1.
//    - A load (lat 1) followed by a dependent instruction stalls exactly 1 cycle.
//    - A lat 2 op stalls a dependent successor 2 cycles.
//  id_lat > MAX_LAT is illegal; the bench asserts on it; RTL clamps to MAX_LAT.
//  Reset mid-operation clears all tags immediately (async); first edge after release behaves as empty.
// STRUCTURE
//  Add to constants.h:
//    - FWD_RF = 0
//    - LAT_ALU = 0, LAT_LW = 1, LAT_MUL = 2
//  One sub-module: sb_lookup (DEPTH-entry priority match returning {hit, ready, sel}).
//    - Instantiated NSRC times via generate.
//  Top holds the entry shift register, stage-0 load and stall OR.
// TESTING (defaults)
//  1. Reset asserted mid-stream with 3 valid tags -> stage_valid=000, stall=0, fwd_sel=0 same cycle.
//  2. ADD r3 (lat0), next SUB src0=r3 -> fwd_sel0=1 (EX); a further instruction src1=r3 -> fwd_sel1=2, stall=0.
//  3. LW r5 (lat1), next ADD src0=r5 -> stall=1 for exactly 1 cycle, then fwd_sel0=2, stall=0.
//  4. MUL r7 (lat2), next src r7 -> 2 stall cycles, then fwd_sel=3.
//  5. ADD r4, ADD r4, consumer of r4 -> fwd_sel=1 (youngest), not 2.
//     Also: src r0 with a tag rd=0 pending -> fwd_sel=0.
//  6. LW r6 issued with flush=1 -> entry0 invalid.
//     Also: dependent on r6 -> stall=0; NSRC=3, DEPTH=5 build passes cases 2-4 with shifted indices.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: default geometry, bypass select encoding
// and the latency classes decode assigns to each instruction.
package hazard_scoreboard_pkg;

    localparam int AW_DEF      = 5;
    localparam int NSRC_DEF    = 2;
    localparam int DEPTH_DEF   = 3;
    localparam int MAX_LAT_DEF = 2;

    // fwd_sel value meaning "read the register file"
    localparam int FWD_RF = 0;

    typedef enum int {
        LAT_ALU = 0,
        LAT_LW  = 1,
        LAT_MUL = 2
    } latClass_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> scoreboard bundle: issue request, source lookups, and the
// stall / bypass-select answers that steer the EX operand muxes.
interface hazard_scoreboard_if #(
    parameter int AW      = 5,
    parameter int NSRC    = 2,
    parameter int DEPTH   = 3,
    parameter int MAX_LAT = 2
);
    localparam int LW_ = $clog2(MAX_LAT + 1);
    localparam int SW  = $clog2(DEPTH + 1);

    logic                 id_issue;
    logic                 id_reg_write;
    logic [AW-1:0]        id_rd;
    logic [LW_-1:0]       id_lat;
    logic [NSRC*AW-1:0]   id_src_addr;
    logic [NSRC-1:0]      id_src_used;
    logic                 flush;
    logic                 stall;
    logic [NSRC*SW-1:0]   fwd_sel;
    logic [DEPTH-1:0]     stage_valid;

    modport master (
        output id_issue, id_reg_write, id_rd, id_lat, id_src_addr, id_src_used, flush,
        input  stall, fwd_sel, stage_valid
    );

    modport slave (
        input  id_issue, id_reg_write, id_rd, id_lat, id_src_addr, id_src_used, flush,
        output stall, fwd_sel, stage_valid
    );
endinterface

// File: rtl/hazard_scoreboard_sb_lookup.sv
// One source-operand lookup: finds the youngest in-flight producer of addr and
// reports whether its result is already bypassable and from which stage.
module sb_lookup
    import hazard_scoreboard_pkg::*;
#(
    parameter int AW    = 5,
    parameter int DEPTH = 3,
    parameter int LW_   = 2,
    parameter int SW    = 2
) (
    input  logic [AW-1:0]                  addr,
    input  logic                           used,
    input  logic [DEPTH-1:0]               validVec,
    input  logic [DEPTH-1:0][AW-1:0]       rdVec,
    input  logic [DEPTH-1:0][LW_-1:0]      latVec,
    output logic                           hit,
    output logic                           ready,
    output logic [SW-1:0]                  sel
);

    // Scan oldest to youngest so the last match written is the youngest producer.
    always_comb begin
        hit   = 1'b0;
        ready = 1'b0;
        sel   = SW'(FWD_RF);
        if (used && addr != '0) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (validVec[k] && rdVec[k] == addr) begin
                    hit   = 1'b1;
                    ready = (latVec[k] == '0);
                    sel   = (latVec[k] == '0) ? SW'(k + 1) : SW'(FWD_RF);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Destination-tag scoreboard for the post-ID pipeline: shifts in-flight tags each
// cycle and answers per-source bypass selects plus a single ID stall.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int NSRC    = NSRC_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int MAX_LAT = MAX_LAT_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    hazard_scoreboard_if.slave   sb
);
    localparam int LW_ = $clog2(MAX_LAT + 1);
    localparam int SW  = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]           validReg;
    logic [DEPTH-1:0][AW-1:0]   rdReg;
    logic [DEPTH-1:0][LW_-1:0]  latReg;

    logic [NSRC-1:0]            srcHit;
    logic [NSRC-1:0]            srcReady;
    logic                       stallInt;
    logic                       issued;
    logic [LW_-1:0]             latIn;

    // Out-of-range latencies are treated as the slowest legal class.
    assign latIn  = (int'(sb.id_lat) > MAX_LAT) ? LW_'(MAX_LAT) : sb.id_lat;
    assign issued = sb.id_issue & ~stallInt & ~sb.flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            validReg <= '0;
            rdReg    <= '0;
            latReg   <= '0;
        end else begin
            validReg[0] <= issued & sb.id_reg_write & (sb.id_rd != '0);
            rdReg[0]    <= sb.id_rd;
            latReg[0]   <= latIn;
            for (int k = 1; k < DEPTH; k++) begin
                validReg[k] <= validReg[k-1];
                rdReg[k]    <= rdReg[k-1];
                latReg[k]   <= (latReg[k-1] == '0) ? '0 : latReg[k-1] - 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            sb_lookup #(
                .AW    (AW),
                .DEPTH (DEPTH),
                .LW_   (LW_),
                .SW    (SW)
            ) u_lookup (
                .addr     (sb.id_src_addr[gi*AW +: AW]),
                .used     (sb.id_src_used[gi]),
                .validVec (validReg),
                .rdVec    (rdReg),
                .latVec   (latReg),
                .hit      (srcHit[gi]),
                .ready    (srcReady[gi]),
                .sel      (sb.fwd_sel[gi*SW +: SW])
            );
        end
    endgenerate

    // Flush deliberately does not mask stall; only a real issue request can stall.
    assign stallInt       = sb.id_issue & |(srcHit & ~srcReady);
    assign sb.stall       = stallInt;
    assign sb.stage_valid = validReg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized check of hazard_scoreboard against an age-based model:
// a tag issued at cycle c sits in stage k at cycle c+1+k and is bypassable once k >= lat.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int AW      = 5;
    localparam int NSRC    = 2;
    localparam int DEPTH   = 3;
    localparam int MAX_LAT = 2;
    localparam int LW      = $clog2(MAX_LAT + 1);
    localparam int SW      = $clog2(DEPTH + 1);
    localparam int HMAX    = 1024;

    logic clk;
    logic rstN;
    int   checks;
    int   failures;
    int   cyc;
    int   floorCyc;

    bit   hValid [HMAX];
    int   hRd    [HMAX];
    int   hLat   [HMAX];

    hazard_scoreboard_if #(.AW(AW), .NSRC(NSRC), .DEPTH(DEPTH), .MAX_LAT(MAX_LAT)) sbIf ();

    hazard_scoreboard #(.AW(AW), .NSRC(NSRC), .DEPTH(DEPTH), .MAX_LAT(MAX_LAT)) dut (
        .clock (clk),
        .reset (rstN),
        .sb    (sbIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rstN && sbIf.id_issue)
            assert (int'(sbIf.id_lat) <= MAX_LAT) else $error("illegal id_lat %0d", sbIf.id_lat);
    end

    task automatic drive(input bit iss, input bit rw, input int rd, input int lat,
                         input int s0, input int s1, input bit [1:0] used, input bit fl);
        sbIf.id_issue     = iss;
        sbIf.id_reg_write = rw;
        sbIf.id_rd        = AW'(rd);
        sbIf.id_lat       = LW'(lat);
        sbIf.id_src_addr  = {AW'(s1), AW'(s0)};
        sbIf.id_src_used  = used;
        sbIf.flush        = fl;
    endtask

    // One ID cycle: drive, compare against the model, then advance the model on the edge.
    task automatic step(input bit iss, input bit rw, input int rd, input int lat,
                        input int s0, input int s1, input bit [1:0] used, input bit fl);
        int                  src [NSRC];
        logic                expStall;
        logic [NSRC*SW-1:0]  expSel;
        logic [DEPTH-1:0]    expSv;
        bit                  issued;
        drive(iss, rw, rd, lat, s0, s1, used, fl);
        #1;
        src[0]   = s0;
        src[1]   = s1;
        expStall = 1'b0;
        expSel   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            int ic = cyc - 1 - k;
            expSv[k] = (ic >= floorCyc && ic >= 0) ? hValid[ic] : 1'b0;
        end
        for (int i = 0; i < NSRC; i++) begin
            bit found = 0;
            if (used[i] && src[i] != 0) begin
                for (int k = 0; k < DEPTH; k++) begin
                    int ic = cyc - 1 - k;
                    if (!found && expSv[k] && hRd[ic] == src[i]) begin
                        found = 1;
                        if (k >= hLat[ic]) expSel[i*SW +: SW] = SW'(k + 1);
                        else               expStall = 1'b1;
                    end
                end
            end
        end
        expStall = expStall & iss;

        checks++;
        assert (sbIf.stall === expStall) else begin
            failures++;
            $error("FAIL stall cyc=%0d observed=%0b expected=%0b", cyc, sbIf.stall, expStall);
        end
        checks++;
        assert (sbIf.fwd_sel === expSel) else begin
            failures++;
            $error("FAIL fwd_sel cyc=%0d observed=%h expected=%h", cyc, sbIf.fwd_sel, expSel);
        end
        checks++;
        assert (sbIf.stage_valid === expSv) else begin
            failures++;
            $error("FAIL stage_valid cyc=%0d observed=%b expected=%b", cyc, sbIf.stage_valid, expSv);
        end
        $display("step cyc=%0d iss=%0b rd=%0d lat=%0d s0=%0d s1=%0d used=%b fl=%0b -> stall=%0b fwd=%h sv=%b",
                 cyc, iss, rd, lat, s0, s1, used, fl, sbIf.stall, sbIf.fwd_sel, sbIf.stage_valid);

        issued      = iss && !expStall && !fl;
        hValid[cyc] = issued && rw && rd != 0;
        hRd[cyc]    = rd;
        hLat[cyc]   = lat;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear before any edge.
    task automatic midReset();
        drive(1'b1, 1'b1, 9, 0, 1, 2, 2'b11, 1'b0);
        rstN = 1'b0;
        #1;
        checks++;
        assert (sbIf.stage_valid === '0) else begin
            failures++;
            $error("FAIL reset_sv observed=%b expected=0", sbIf.stage_valid);
        end
        checks++;
        assert (sbIf.stall === 1'b0 && sbIf.fwd_sel === '0) else begin
            failures++;
            $error("FAIL reset_out observed=stall%0b/fwd%h expected=0/0", sbIf.stall, sbIf.fwd_sel);
        end
        $display("reset cyc=%0d sv=%b stall=%0b fwd=%h", cyc, sbIf.stage_valid, sbIf.stall, sbIf.fwd_sel);
        @(posedge clk);
        #1;
        rstN        = 1'b1;
        hValid[cyc] = 1'b0;
        cyc++;
        floorCyc    = cyc;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        floorCyc = 0;
        rstN     = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;

        // Build three valid tags, then reset with them in flight.
        step(1, 1, 1, LAT_ALU, 0, 0, 2'b00, 0);
        step(1, 1, 2, LAT_ALU, 0, 0, 2'b00, 0);
        step(1, 1, 3, LAT_ALU, 0, 0, 2'b00, 0);
        midReset();

        // ALU producer forwarded from EX, then from MEM.
        step(1, 1, 3, LAT_ALU, 0, 0, 2'b00, 0);
        step(1, 1, 8, LAT_ALU, 3, 0, 2'b01, 0);
        step(1, 1, 9, LAT_ALU, 0, 3, 2'b10, 0);
        step(0, 0, 0, 0, 0, 0, 2'b00, 0);

        // Load-use: one stall cycle.
        step(1, 1, 5, LAT_LW, 0, 0, 2'b00, 0);
        step(1, 1, 10, LAT_ALU, 5, 0, 2'b01, 0);
        step(1, 1, 10, LAT_ALU, 5, 0, 2'b01, 0);
        step(0, 0, 0, 0, 0, 0, 2'b00, 0);

        // Multi-cycle: two stall cycles.
        step(1, 1, 7, LAT_MUL, 0, 0, 2'b00, 0);
        step(1, 1, 11, LAT_ALU, 0, 7, 2'b10, 0);
        step(1, 1, 11, LAT_ALU, 0, 7, 2'b10, 0);
        step(1, 1, 11, LAT_ALU, 0, 7, 2'b10, 0);
        step(0, 0, 0, 0, 0, 0, 2'b00, 0);

        // WAW: youngest producer wins; r0 never matches.
        step(1, 1, 4, LAT_ALU, 0, 0, 2'b00, 0);
        step(1, 1, 4, LAT_ALU, 0, 0, 2'b00, 0);
        step(1, 1, 0, LAT_LW, 4, 0, 2'b01, 0);
        step(1, 0, 0, LAT_ALU, 0, 0, 2'b11, 0);

        // Flushed load leaves no tag.
        step(1, 1, 6, LAT_LW, 0, 0, 2'b00, 1);
        step(1, 1, 12, LAT_ALU, 6, 6, 2'b11, 0);
        step(0, 0, 0, 0, 0, 0, 2'b00, 0);

        // Randomized traffic over a small register window to force frequent hits.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) midReset();
            step($urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 8,
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, MAX_LAT)),
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 9) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
